// File: rtl/sniffer_pkg.sv
// Shared constants, FSM state type and pattern storage type for the string-match sniffer.
package sniffer_pkg;
    localparam int MAX_STRLEN   = 17;
    localparam int DRAIN_CYCLES = 2;
    localparam int LEN_W        = 5;
    localparam int DRAIN_W      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_REPORT,
        ST_CLEAR
    } state_e;

    // Byte i of the pattern lives at index i; patterns are right-aligned (end at index 16).
    typedef logic [MAX_STRLEN-1:0][7:0] pattern_t;

    function automatic logic pattern_ok(input pattern_t pat, input logic [LEN_W-1:0] len);
        logic ok;
        ok = (len != '0) && (int'(len) <= MAX_STRLEN);
        for (int i = 0; i < MAX_STRLEN; i++) begin
            if ((i >= MAX_STRLEN - int'(len)) && (pat[i] == 8'h00)) ok = 1'b0;
        end
        return ok;
    endfunction
endpackage

// File: rtl/string_match_controller_if.sv
// Packet stream into the controller and the per-packet verdict back out.
interface string_match_controller_if;
    logic        pkt_start;
    logic        pkt_end;
    logic        data_valid;
    logic [31:0] data_in;
    logic        match_valid;
    logic        match_flag;

    modport master (output pkt_start, pkt_end, data_valid, data_in,
                    input  match_valid, match_flag);
    modport slave  (input  pkt_start, pkt_end, data_valid, data_in,
                    output match_valid, match_flag);
endinterface

// File: rtl/string_cfg_shadow.sv
// Staged/active pattern store with commit validation; a commit made while busy waits for idle.
// Commit lands one cycle later (or on entry to IDLE); cfg_err pulses the cycle after a rejected commit.
module string_cfg_shadow
    import sniffer_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             idle_i,
    input  logic             to_idle_i,
    input  logic             cfg_wr,
    input  logic [4:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_commit,
    output pattern_t         flagged_string,
    output logic [LEN_W-1:0] strlen,
    output logic             cfg_err
);
    pattern_t         staged_q, staged_d, active_q, active_d, pend_pat_q, pend_pat_d;
    logic [LEN_W-1:0] len_q, len_d, pend_len_q, pend_len_d;
    logic             pend_q, pend_d, cfg_err_q, commit_ok;

    assign commit_ok = pattern_ok(staged_q, cfg_len);

    always_comb begin
        staged_d   = staged_q;
        active_d   = active_q;
        len_d      = len_q;
        pend_d     = pend_q;
        pend_pat_d = pend_pat_q;
        pend_len_d = pend_len_q;
        if (cfg_wr && (cfg_addr < 5'(MAX_STRLEN))) staged_d[cfg_addr] = cfg_data;
        // CLEAR is the last busy cycle, so a commit seen there can land directly.
        if (cfg_commit && commit_ok) begin
            if (idle_i || to_idle_i) begin
                active_d = staged_q;
                len_d    = cfg_len;
                pend_d   = 1'b0;
            end else begin
                pend_d     = 1'b1;
                pend_pat_d = staged_q;
                pend_len_d = cfg_len;
            end
        end else if (pend_q && to_idle_i) begin
            active_d = pend_pat_q;
            len_d    = pend_len_q;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            staged_q   <= '0;
            active_q   <= '0;
            len_q      <= LEN_W'(MAX_STRLEN);
            pend_q     <= 1'b0;
            pend_pat_q <= '0;
            pend_len_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            staged_q   <= staged_d;
            active_q   <= active_d;
            len_q      <= len_d;
            pend_q     <= pend_d;
            pend_pat_q <= pend_pat_d;
            pend_len_q <= pend_len_d;
            cfg_err_q  <= cfg_commit && !commit_ok;
        end
    end

    assign flagged_string = active_q;
    assign strlen         = len_q;
    assign cfg_err        = cfg_err_q;
endmodule

// File: rtl/string_match_controller.sv
// Streams packet words into an external comparator and reports one verdict per packet.
// Verdict 3 cycles after the last word, comparator clear at +4, back to IDLE at +5; no backpressure.
module string_match_controller
    import sniffer_pkg::*;
(
    input  logic                      clk,
    input  logic                      n_rst,
    string_match_controller_if.slave  pkt,
    input  logic                      cfg_wr,
    input  logic [4:0]                cfg_addr,
    input  logic [7:0]                cfg_data,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic                      cfg_commit,
    input  logic                      cmp_match,
    output logic                      cmp_clear,
    output logic [31:0]               cmp_data,
    output pattern_t                  flagged_string,
    output logic [LEN_W-1:0]          strlen,
    output logic                      busy,
    output logic                      cfg_err,
    output logic [15:0]               drop_cnt
);
    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [15:0]        drop_q, drop_d;
    logic               start_req, accept;

    assign start_req = pkt.pkt_start && pkt.data_valid;

    always_comb begin
        state_d         = state_q;
        drain_d         = drain_q;
        accept          = 1'b0;
        cmp_clear       = 1'b0;
        pkt.match_valid = 1'b0;
        pkt.match_flag  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    accept  = 1'b1;
                    state_d = pkt.pkt_end ? ST_DRAIN : ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A stray pkt_start mid-packet is only counted; its word is still payload.
                accept = pkt.data_valid;
                if (pkt.data_valid && pkt.pkt_end) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    drain_d = '0;
                    state_d = ST_REPORT;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_REPORT: begin
                pkt.match_valid = 1'b1;
                pkt.match_flag  = cmp_match;
                state_d         = ST_CLEAR;
            end
            ST_CLEAR: begin
                cmp_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (start_req && (state_q != ST_IDLE) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            drop_q  <= drop_d;
        end
    end

    assign cmp_data = accept ? pkt.data_in : 32'h0;
    assign busy     = (state_q != ST_IDLE);
    assign drop_cnt = drop_q;

    string_cfg_shadow u_cfg (
        .clk            (clk),
        .n_rst          (n_rst),
        .idle_i         (state_q == ST_IDLE),
        .to_idle_i      (state_q == ST_CLEAR),
        .cfg_wr         (cfg_wr),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_len        (cfg_len),
        .cfg_commit     (cfg_commit),
        .flagged_string (flagged_string),
        .strlen         (strlen),
        .cfg_err        (cfg_err)
    );
endmodule

// File: tb/tb_string_match_controller.sv
// Directed bench: latency-based reference model plus a behavioural comparator driving cmp_match.
module tb_string_match_controller;
    import sniffer_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cfg_wr, cfg_commit, cmp_match;
    logic [4:0]  cfg_addr, cfg_len;
    logic [7:0]  cfg_data;
    logic        cmp_clear, busy, cfg_err;
    logic [31:0] cmp_data;
    pattern_t    flagged_string;
    logic [4:0]  strlen;
    logic [15:0] drop_cnt;

    string_match_controller_if pkt_if ();

    string_match_controller dut (
        .clk(clk), .n_rst(n_rst), .pkt(pkt_if),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
        .cfg_commit(cfg_commit), .cmp_match(cmp_match), .cmp_clear(cmp_clear),
        .cmp_data(cmp_data), .flagged_string(flagged_string), .strlen(strlen),
        .busy(busy), .cfg_err(cfg_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A zero pattern byte never matches, so an unconfigured pattern finds nothing.
    function automatic bit has_pat(input logic [7:0] b[$], input pattern_t p, input int len);
        bit hit;
        if (len < 1 || len > MAX_STRLEN) return 1'b0;
        for (int k = 0; k < len; k++) if (p[MAX_STRLEN-len+k] == 8'h00) return 1'b0;
        for (int s = 0; s + len <= b.size(); s++) begin
            hit = 1'b1;
            for (int k = 0; k < len; k++) if (b[s+k] != p[MAX_STRLEN-len+k]) hit = 1'b0;
            if (hit) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit cfg_valid(input pattern_t p, input int len);
        if (len < 1 || len > MAX_STRLEN) return 1'b0;
        for (int i = MAX_STRLEN - len; i < MAX_STRLEN; i++) if (p[i] == 8'h00) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model state
    pattern_t   m_stg, m_act, m_pend;
    int         m_len, m_pend_len, m_age, m_drop;
    bit         m_pend_v, m_err_nxt, m_in_pkt;
    logic [7:0] m_bytes[$];
    logic [7:0] c_hist[$];
    // Observations for the literal checks
    int  cyc = 0, verdicts = 0, last_flag = -1, mv_cyc = 0, clr_cyc = 0, idle_cyc = 0;
    int  end_cyc = 0, errs = 0;
    bit  prev_busy = 1'b0;

    always @(negedge clk) begin
        bit          idle, acc, mv, clr, bz;
        logic [31:0] exp_cd, din;
        cyc++;
        din = pkt_if.data_in;
        if (!n_rst) begin
            chk("rst_busy", busy, 0);
            chk("rst_match_valid", pkt_if.match_valid, 0);
            chk("rst_cmp_clear", cmp_clear, 0);
            chk("rst_cfg_err", cfg_err, 0);
            chk("rst_cmp_data", cmp_data, 0);
            chk("rst_strlen", strlen, 17);
            chk("rst_flagged", flagged_string, 0);
            chk("rst_drop", drop_cnt, 0);
            m_stg = '0; m_act = '0; m_pend = '0; m_len = 17; m_pend_len = 0;
            m_pend_v = 0; m_err_nxt = 0; m_in_pkt = 0; m_age = 0; m_drop = 0;
            m_bytes.delete(); c_hist.delete(); cmp_match = 1'b0; prev_busy = 1'b0;
        end else begin
            // m_age counts cycles since the last word of a packet (1..4), 0 when none pending.
            bz   = m_in_pkt || (m_age > 0);
            idle = !bz;
            mv   = (m_age == 3);
            clr  = (m_age == 4);
            acc  = (idle && pkt_if.pkt_start && pkt_if.data_valid) || (m_in_pkt && pkt_if.data_valid);
            exp_cd = acc ? din : 32'h0;
            chk("busy", busy, bz);
            chk("match_valid", pkt_if.match_valid, mv);
            chk("cmp_clear", cmp_clear, clr);
            chk("cfg_err", cfg_err, m_err_nxt);
            chk("cmp_data", cmp_data, exp_cd);
            chk("strlen", strlen, m_len);
            chk("flagged_string", flagged_string, m_act);
            chk("drop_cnt", drop_cnt, m_drop);
            if (mv) chk("match_flag", pkt_if.match_flag, has_pat(m_bytes, m_act, m_len));

            if (pkt_if.match_valid) begin
                verdicts++; last_flag = int'(pkt_if.match_flag); mv_cyc = cyc;
            end
            if (cmp_clear) clr_cyc = cyc;
            if (cfg_err) errs++;
            if (!busy && prev_busy) idle_cyc = cyc;
            prev_busy = busy;

            m_err_nxt = 0;
            if (cfg_commit) begin
                if (!cfg_valid(m_stg, int'(cfg_len))) m_err_nxt = 1;
                else if (idle || clr) begin m_act = m_stg; m_len = int'(cfg_len); m_pend_v = 0; end
                else begin m_pend = m_stg; m_pend_len = int'(cfg_len); m_pend_v = 1; end
            end else if (m_pend_v && clr) begin
                m_act = m_pend; m_len = m_pend_len; m_pend_v = 0;
            end
            if (cfg_wr && cfg_addr < 5'd17) m_stg[cfg_addr] = cfg_data;
            if (!idle && pkt_if.pkt_start && pkt_if.data_valid && m_drop < 65535) m_drop++;
            if (idle && pkt_if.pkt_start && pkt_if.data_valid) begin m_bytes.delete(); m_in_pkt = 1; end
            if (acc) for (int k = 3; k >= 0; k--) m_bytes.push_back(din[k*8 +: 8]);
            else if (m_in_pkt) for (int k = 0; k < 4; k++) m_bytes.push_back(8'h00);
            if (acc && pkt_if.pkt_end) begin m_in_pkt = 0; m_age = 1; end_cyc = cyc; end
            else if (m_age > 0) m_age = (m_age == 4) ? 0 : m_age + 1;

            // Comparator: sticky match over everything driven on cmp_data since the last clear.
            if (cmp_clear) begin
                c_hist.delete(); cmp_match = 1'b0;
            end else begin
                for (int k = 3; k >= 0; k--) c_hist.push_back(cmp_data[k*8 +: 8]);
                while (c_hist.size() > 20) void'(c_hist.pop_front());
                if (has_pat(c_hist, flagged_string, int'(strlen))) cmp_match = 1'b1;
            end
        end
    end

    task automatic tick(input bit ps, input bit pe, input bit dv, input logic [31:0] d);
        pkt_if.pkt_start = ps; pkt_if.pkt_end = pe; pkt_if.data_valid = dv; pkt_if.data_in = d;
        @(posedge clk); #1;
        pkt_if.pkt_start = 0; pkt_if.pkt_end = 0; pkt_if.data_valid = 0; pkt_if.data_in = 0;
        cfg_wr = 0; cfg_commit = 0;
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick(0, 0, 0, 32'h0);
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        cfg_wr = 1; cfg_addr = 5'(a); cfg_data = d;
        tick(0, 0, 0, 32'h0);
    endtask

    task automatic commit(input int len);
        cfg_len = 5'(len); cfg_commit = 1;
        tick(0, 0, 0, 32'h0);
    endtask

    task automatic load_attack();
        logic [7:0] atk [6];
        atk = '{8'h41, 8'h54, 8'h54, 8'h41, 8'h43, 8'h4B};
        for (int i = 0; i < 6; i++) wr(11 + i, atk[i]);
        commit(6);
    endtask

    initial begin
        n_rst = 0; cfg_wr = 0; cfg_commit = 0; cfg_addr = 0; cfg_data = 0; cfg_len = 0;
        cmp_match = 0;
        pkt_if.pkt_start = 0; pkt_if.pkt_end = 0; pkt_if.data_valid = 0; pkt_if.data_in = 0;
        idle_n(3);
        n_rst = 1;
        idle_n(2);
        chk("lit_rst_strlen", strlen, 17);

        load_attack();
        idle_n(1);
        chk("lit_strlen_attack", strlen, 6);
        chk("lit_byte11", flagged_string[11], 8'h41);
        chk("lit_byte16", flagged_string[16], 8'h4B);

        // "xxAT" "TACK" "yyyy": match straddles the first word boundary
        tick(1, 0, 1, 32'h7878_4154);
        tick(0, 0, 1, 32'h5441_434B);
        tick(0, 1, 1, 32'h7979_7979);
        idle_n(7);
        chk("lit_A_verdicts", verdicts, 1);
        chk("lit_A_flag", last_flag, 1);
        chk("lit_A_mv_lat", mv_cyc - end_cyc, 3);
        chk("lit_A_clr_lat", clr_cyc - end_cyc, 4);

        tick(1, 1, 1, 32'h1234_5678);
        idle_n(7);
        chk("lit_B_verdicts", verdicts, 2);
        chk("lit_B_flag", last_flag, 0);
        chk("lit_B_mv_lat", mv_cyc - end_cyc, 3);
        chk("lit_B_idle_lat", idle_cyc - end_cyc, 5);

        commit(0);  idle_n(1);
        commit(18); idle_n(1);
        wr(14, 8'h00);
        commit(4);  idle_n(2);
        chk("lit_cfg_errs", errs, 3);
        chk("lit_strlen_kept", strlen, 6);
        wr(14, 8'h41);

        // Commit "TACK" mid-packet: must wait until the packet is fully reported
        tick(1, 0, 1, 32'h4154_5441);
        cfg_len = 5'd4; cfg_commit = 1;
        tick(0, 0, 1, 32'h434B_0000);
        chk("lit_C_strlen_busy", strlen, 6);
        tick(0, 1, 1, 32'h2020_2020);
        idle_n(2);
        chk("lit_C_strlen_busy2", strlen, 6);
        idle_n(5);
        chk("lit_C_strlen_new", strlen, 4);
        chk("lit_C_byte13", flagged_string[13], 8'h54);
        chk("lit_C_flag", last_flag, 1);

        // New starts during DRAIN and REPORT are dropped
        tick(1, 1, 1, 32'h5441_434B);
        tick(1, 0, 1, 32'hAAAA_AAAA);
        tick(0, 0, 0, 32'h0);
        tick(1, 1, 1, 32'hBBBB_BBBB);
        idle_n(6);
        chk("lit_D_drop", drop_cnt, 2);
        chk("lit_D_verdicts", verdicts, 4);
        chk("lit_D_flag", last_flag, 1);
        chk("lit_D_mv_lat", mv_cyc - end_cyc, 3);

        // Reset in the middle of a matching packet
        tick(1, 0, 1, 32'h4154_5441);
        tick(0, 0, 1, 32'h434B_4B4B);
        n_rst = 0;
        idle_n(2);
        chk("lit_R_strlen", strlen, 17);
        chk("lit_R_drop", drop_cnt, 0);
        n_rst = 1;
        tick(1, 1, 1, 32'h0102_0304);
        idle_n(7);
        chk("lit_R_verdicts", verdicts, 5);
        chk("lit_R_flag", last_flag, 0);
        chk("lit_R_mv_lat", mv_cyc - end_cyc, 3);

        load_attack();
        tick(1, 0, 1, 32'h4154_5441);
        tick(0, 1, 1, 32'h434B_0000);
        idle_n(7);
        chk("lit_E_verdicts", verdicts, 6);
        chk("lit_E_flag", last_flag, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/string_match_controller.md
STRING_MATCH_CONTROLLER -- requirements
Module: string_match_controller

Interface
REQ-001 Parameters: none; constants MAX_STRLEN=17, DRAIN_CYCLES=2 come from sniffer_pkg.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 n_rst  in  1  asynchronous, active-low reset.
REQ-004 pkt_start  in  1  first word of packet (qualified by data_valid).
REQ-005 pkt_end  in  1  last word of packet (qualified by data_valid); may coincide with pkt_start.
REQ-006 data_valid  in  1  payload word valid this cycle.
REQ-007 data_in  in  32  payload word.
REQ-008 cfg_wr  in  1  write staged pattern byte.
REQ-009 cfg_addr  in  5  staged byte index 0..16.
REQ-010 cfg_data  in  8  staged byte value.
REQ-011 cfg_len  in  5  staged pattern length (sampled on cfg_commit).
REQ-012 cfg_commit  in  1  request copy of staged pattern to active pattern.
REQ-013 cmp_match  in  1  sticky match from string comparator.
REQ-014 cmp_clear  out  1  clear pulse to comparator.
REQ-015 cmp_data  out  32  word driven into comparator.
REQ-016 flagged_string  out  17x8  active pattern, byte 0 first.
REQ-017 strlen  out  5  active pattern length.
REQ-018 match_valid  out  1  one-cycle per-packet verdict strobe.
REQ-019 match_flag  out  1  verdict (1 = pattern found); valid with match_valid.
REQ-020 busy  out  1  high in any state except IDLE.
REQ-021 cfg_err  out  1  one-cycle pulse on rejected commit.
REQ-022 drop_cnt  out  16  saturating count of ignored pkt_start.

Function
REQ-023 FSM states: IDLE, STREAM, DRAIN, REPORT, CLEAR.
REQ-024 IDLE: pkt_start&data_valid -> STREAM (DRAIN if pkt_end same cycle); word forwarded that cycle.
REQ-025 STREAM: pkt_end&data_valid -> DRAIN; otherwise stay.
REQ-026 cmp_data = data_in when a word is accepted (IDLE start or STREAM with data_valid), else 32'h0.
REQ-027 Gap cycles (STREAM, data_valid=0) push zero word; matches spanning a gap are not required.
REQ-028 DRAIN lasts exactly DRAIN_CYCLES cycles with cmp_data=0, then -> REPORT.
REQ-029 REPORT (one cycle): match_valid=1, match_flag=cmp_match -> CLEAR.
REQ-030 CLEAR (one cycle): cmp_clear=1, cmp_data=0 -> IDLE.
REQ-031 Latency: pkt_end accepted cycle T -> match_valid at T+3, cmp_clear at T+4, IDLE at T+5.
REQ-032 pkt_start&data_valid outside IDLE: ignored, drop_cnt+1 (saturate at 16'hFFFF); current packet unaffected.
REQ-033 cfg_wr writes staged byte anytime; cfg_addr>16 ignored.
REQ-034 Commit rejected (cfg_err pulse, active pattern unchanged) if cfg_len=0, cfg_len>17, or any staged byte in the last cfg_len positions (indices 17-cfg_len..16) is 8'h00.
REQ-035 Valid commit in IDLE applies next cycle; valid commit while busy is held pending and applied on the cycle FSM enters IDLE; later commit overwrites pending.
REQ-036 flagged_string/strlen never change while busy.
REQ-037 cmp_clear, match_valid, cfg_err are never asserted outside their defined cycles.

Reset
REQ-038 n_rst low: state IDLE; active and staged pattern all 8'h00; strlen=17; pending commit cleared; drop_cnt=0; all strobes 0; cmp_data=0.
REQ-039 Reset mid-packet abandons it with no match_valid; first cycle after reset release accepts a new pkt_start.

Structure
REQ-040 sniffer_pkg holds MAX_STRLEN, DRAIN_CYCLES, state enum type, pattern array typedef.
REQ-041 Sub-module string_cfg_shadow holds staged/active pattern, validation and pending commit; FSM stays in top.

Verification
REQ-042 Pattern "ATTACK" (len 6) committed; 3-word packet containing it across word boundary -> match_valid at T+3, match_flag=1, cmp_clear at T+4.
REQ-043 Single-word packet (start&end) without pattern -> match_flag=0 at T+3, IDLE at T+5.
REQ-044 cfg_len=0, then cfg_len=18, then len 4 with 8'h00 in pattern -> three cfg_err pulses, strlen unchanged.
REQ-045 Commit during STREAM -> strlen/flagged_string stable until IDLE, then new values.
REQ-046 pkt_start during DRAIN and REPORT -> drop_cnt=2, single verdict for original packet.
REQ-047 n_rst low during STREAM -> no match_valid, outputs at reset values, next packet processed normally.
